block_config_loader: RTL and testbench
======================================

Name: block_config_loader

Overview:
- Configuration controller that drives the block-style config port of a column of SLICEL config-latch blocks.
- Accepts a serial bitstream over a valid/ready handshake and assembles one MEM_SIZE-bit word per block.
- Presents each word on a shared config_out bus and pulses that block's comb_set line for exactly one cycle.
- Sits between the chip-level config shifter and the per-slice latch blocks.

Parameters:
- ADDR_BITS, 4, LUT address width of each target block.
- MEM_SIZE, 2**ADDR_BITS, bits per target block word.
- NUM_BLOCKS, 8, number of target blocks programmed per frame.
- BLK_IDX_BITS, $clog2(NUM_BLOCKS), width of the internal block index (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  begins a frame; sampled only in IDLE.
- cfg_bit  in  1  serial config data bit.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_ready  out  1  loader accepts cfg_bit this cycle.
- config_out  out  MEM_SIZE  word bus shared by all target blocks.
- comb_set  out  NUM_BLOCKS  one-hot commit strobe, one bit per target block.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at the end of a frame.
- err  out  1  sticky parity error flag; tied 0 without the optional feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE; config_out=0, comb_set=0, cfg_ready=0, busy=0, done=0, err=0; bit counter and block index cleared.
- Reset mid-frame: abort immediately with no comb_set pulse. Blocks already committed keep their contents.
- IDLE: cfg_ready=0. On cfg_start: block index=0, bit count=0, err=0, go to LOAD.
- LOAD:
  - cfg_ready=1.
  - Transfer occurs on cycles where cfg_valid & cfg_ready.
  - Word is sent LSB first. The k-th accepted bit of a word lands in shift[k]: shift right, new bit into the MSB.
  - When the last bit of a word is accepted, go to COMMIT. cfg_ready drops to 0 in the following cycle.
  - cfg_valid low stalls LOAD indefinitely with no timeout.
- COMMIT (one cycle):
  - config_out and comb_set[index] are both registered and are updated at the same edge.
  - config_out = assembled word; comb_set[index]=1, all other bits 0.
  - The target latch captures on the next posedge, while comb_set is high.
  - config_out holds its value until the next COMMIT overwrites it.
  - If index==NUM_BLOCKS-1, go to DONE. Otherwise increment index, clear bit count and go to LOAD.
- DONE (one cycle): done=1, then go to IDLE.
- Latency: last bit accepted in cycle N → comb_set high in cycle N+1. Next LOAD acceptance occurs no earlier than cycle N+2.
- A full frame with back-to-back valid takes NUM_BLOCKS×(MEM_SIZE+1)+1 cycles from the first accepted bit to done.
- cfg_start is ignored outside IDLE. cfg_start together with valid in IDLE: no bit is accepted that cycle.
- comb_set is never multi-hot and is never asserted outside COMMIT.

Optional Feature:
- Macro: CONFIG_PARITY_EN.
- Defined:
  - Each word is followed by one parity bit, giving MEM_SIZE+1 accepted bits per word.
  - Even parity over word plus parity bit.
  - Mismatch: COMMIT still occupies its cycle but comb_set stays 0. config_out is left unchanged, err is set sticky, and the index still advances.
  - err clears only on reset or on cfg_start.
- Undefined: MEM_SIZE bits per word; err is tied to 0.

Decomposition:
- Shared package cfg_pkg:
  - state enum (IDLE, LOAD, COMMIT, DONE);
  - default constants for ADDR_BITS, MEM_SIZE and NUM_BLOCKS;
  - parity bit count localparam, set from CONFIG_PARITY_EN.
- One natural sub-module, cfg_word_shifter: the serial-in shift register plus bit counter and word_full flag, and the parity accumulator when the feature is on.
- The loader top holds the FSM, the block index and the one-hot decode.

Test Plan:
1. Reset → all outputs 0 and busy=0. Assert rst_n=0 in the middle of the 3rd word → no comb_set pulse; IDLE on release.
2. cfg_start, then 8 back-to-back words 16'hA5F0+i (i=0..7), LSB first. Each word produces one comb_set pulse (bits 0..7 in order) with config_out equal to that word. done pulses once; the frame spans 8×17+1 cycles.
3. Random cfg_valid gaps (~50% duty) with the same data → identical comb_set/config_out sequence; no bit is lost or duplicated.
4. Toggle cfg_start during LOAD/COMMIT → ignored; index and data are unaffected.
5. MEM_SIZE=16, NUM_BLOCKS=1 → a single commit, then done in the cycle after COMMIT.
6. CONFIG_PARITY_EN: correct parity on words 0 and 2, bad parity on word 1 → comb_set[1] never pulses, err=1 and stays set, word 2 still commits, then cfg_start clears err.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the block config loader.
// Holds default geometry, FSM state encoding, the per-word parity bit
// count and a helper for index widths.
// Optional feature macro: CONFIG_PARITY_EN (one even-parity bit per word).
package cfg_pkg;

  localparam int unsigned ADDR_BITS_DEF  = 4;
  localparam int unsigned MEM_SIZE_DEF   = 2 ** ADDR_BITS_DEF;
  localparam int unsigned NUM_BLOCKS_DEF = 8;

`ifdef CONFIG_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Loader FSM state encoding
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] cfg_state_t;
  localparam cfg_state_t ST_IDLE   = 2'd0;
  localparam cfg_state_t ST_LOAD   = 2'd1;
  localparam cfg_state_t ST_COMMIT = 2'd2;
  localparam cfg_state_t ST_DONE   = 2'd3;

  // Index width with a floor of one bit so a single-block column still works
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_shifter.sv
// Serial-in word assembler for the config loader.
// Shifts accepted bits in LSB first (new bit enters at the MSB, older bits
// move right), counts bits per word and flags the last bit combinationally
// so the loader can commit in the very next cycle.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   clear_i         drop any partial word (frame start)
//   shift_en_i      accept bit_i this cycle
//   bit_i           serial data bit
//   word_nxt_c      assembled word including the bit being accepted now
//   word_full_c     the bit being accepted now completes the word
//   par_ok_c        even parity holds over word + parity bit (1 when disabled)
// Optional feature macro: CONFIG_PARITY_EN.
module cfg_word_shifter
  import cfg_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                shift_en_i,
  input  logic                bit_i,
  output logic [MEM_SIZE-1:0] word_nxt_c,
  output logic                word_full_c,
  output logic                par_ok_c
);

  localparam int unsigned WORD_BITS = MEM_SIZE + PARITY_BITS;
  // The final bit never needs storing: it is merged straight into word_nxt_c.
  localparam int unsigned SHIFT_W   = WORD_BITS - 1;
  localparam int unsigned CNT_W     = $clog2(WORD_BITS + 1);

  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shift_nxt;

  // View of the register after this cycle's shift
  always_comb begin
    shift_nxt   = {bit_i, shift_q};
    word_nxt_c  = shift_nxt[MEM_SIZE-1:0];
    word_full_c = shift_en_i && (cnt_q == CNT_W'(WORD_BITS - 1));
  end

  // Shift register and bit counter next state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = shift_nxt[WORD_BITS-1:1];
      cnt_d   = word_full_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CONFIG_PARITY_EN
  logic par_q, par_d;

  // Running XOR of the word so far; restarts after every word
  always_comb begin
    par_d    = par_q;
    par_ok_c = ~(par_q ^ bit_i);
    if (clear_i) begin
      par_d = 1'b0;
    end else if (shift_en_i) begin
      par_d = word_full_c ? 1'b0 : (par_q ^ bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign par_ok_c = 1'b1;
`endif

endmodule

// File: rtl/block_config_loader.sv
// Configuration controller for a column of SLICEL config-latch blocks.
// Assembles one word per block from a valid/ready serial stream, drives it
// on the shared config_out bus and strobes that block's comb_set bit for
// exactly one cycle.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   cfg_start    begin a frame (only honoured in IDLE)
//   cfg_bit      serial data bit, qualified by cfg_valid
//   cfg_valid    cfg_bit present
//   cfg_ready    loader accepts cfg_bit this cycle
//   config_out   word bus shared by all target blocks
//   comb_set     one-hot commit strobe, one bit per block
//   busy         loader is not in IDLE
//   done         one-cycle end-of-frame pulse
//   err          sticky parity error (0 when parity is disabled)
// Optional feature macro: CONFIG_PARITY_EN.
module block_config_loader
  import cfg_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = ADDR_BITS_DEF,
  parameter int unsigned MEM_SIZE     = 2 ** ADDR_BITS,
  parameter int unsigned NUM_BLOCKS   = NUM_BLOCKS_DEF,
  parameter int unsigned BLK_IDX_BITS = idx_bits(NUM_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_bit,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [MEM_SIZE-1:0]   config_out,
  output logic [NUM_BLOCKS-1:0] comb_set,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  cfg_state_t              state_q, state_d;
  logic [BLK_IDX_BITS-1:0] idx_q, idx_d;
  logic                    ready_q, ready_d;
  logic [MEM_SIZE-1:0]     out_q, out_d;
  logic [NUM_BLOCKS-1:0]   set_q, set_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    frame_start;
  logic [MEM_SIZE-1:0]     word_nxt;
  logic                    word_full;
  logic                    par_ok;

  assign accept      = cfg_valid && ready_q;
  assign frame_start = (state_q == ST_IDLE) && cfg_start;

  cfg_word_shifter #(
    .MEM_SIZE (MEM_SIZE)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (frame_start),
    .shift_en_i  (accept),
    .bit_i       (cfg_bit),
    .word_nxt_c  (word_nxt),
    .word_full_c (word_full),
    .par_ok_c    (par_ok)
  );

`ifdef CONFIG_PARITY_EN
  logic err_q, err_d;
`endif

  // Next state and registered outputs. Commit outputs are loaded on the
  // edge that accepts the last bit, so they are live during COMMIT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    out_d   = out_q;
    set_d   = '0;
    done_d  = 1'b0;
`ifdef CONFIG_PARITY_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          idx_d   = '0;
          state_d = ST_LOAD;
          ready_d = 1'b1;
`ifdef CONFIG_PARITY_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        ready_d = 1'b1;
        if (word_full) begin
          state_d = ST_COMMIT;
          ready_d = 1'b0;
          if (par_ok) begin
            out_d = word_nxt;
            set_d = NUM_BLOCKS'(1) << idx_q;
          end
`ifdef CONFIG_PARITY_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end
      end
      ST_COMMIT: begin
        if (idx_q == BLK_IDX_BITS'(NUM_BLOCKS - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + BLK_IDX_BITS'(1);
          state_d = ST_LOAD;
          ready_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      out_q   <= '0;
      set_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      set_q   <= set_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CONFIG_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cfg_ready  = ready_q;
  assign config_out = out_q;
  assign comb_set   = set_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_block_config_loader.sv
// Directed bench for block_config_loader: table of expected commits per
// frame plus hand-written sequences for reset, single-block and parity.
module tb_block_config_loader;

  localparam int MS = 16;
  localparam int NB = 8;
`ifdef CONFIG_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WB = MS + PB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_start1, cfg_bit, cfg_valid;
  logic          cfg_ready, busy, done, err;
  logic [MS-1:0] config_out;
  logic [NB-1:0] comb_set;
  logic          cfg_ready1, busy1, done1, err1;
  logic [MS-1:0] config_out1;
  logic [0:0]    comb_set1;

  always #5 clk = ~clk;

  block_config_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .config_out(config_out),
    .comb_set(comb_set), .busy(busy), .done(done), .err(err)
  );

  block_config_loader #(.ADDR_BITS(4), .NUM_BLOCKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start1), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .config_out(config_out1),
    .comb_set(comb_set1), .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct {
    logic [MS-1:0] word;
    logic [NB-1:0] exp_set;
  } vec_t;

  typedef struct packed {
    logic [NB-1:0] set;
    logic [MS-1:0] data;
  } rec_t;

  vec_t tbl [NB];
  rec_t q [$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_full_cyc = -10;
  int first_acc = -1;
  int done_cnt = 0;
  int done_cyc = 0;
  logic          err_prev = 1'b0;
  logic [MS-1:0] err_rise_data = '0;
  logic [NB-1:0] err_rise_set = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Commit monitor for the 8-block instance
  always @(negedge clk) begin
    if (!rst_n || !busy) acc_cnt = 0;
    if (rst_n && comb_set != '0) begin
      chk("comb_set_onehot", 32'($onehot(comb_set)), 32'd1);
      chk("commit_latency", 32'(cyc - last_full_cyc), 32'd1);
      chk("busy_in_commit", 32'(busy), 32'd1);
      q.push_back('{comb_set, config_out});
    end
    if (rst_n && cfg_valid && cfg_ready) begin
      if (first_acc < 0) first_acc = cyc;
      acc_cnt++;
      if (acc_cnt == WB) begin
        acc_cnt = 0;
        last_full_cyc = cyc;
      end
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err && !err_prev) begin
      err_rise_data = config_out;
      err_rise_set  = comb_set;
    end
    err_prev = err;
  end

  // Offer one bit and hold it until accepted by the selected instance
  task automatic send_bit(input bit which, input logic b, input bit gaps, input bit toggle);
    bit ok = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      cfg_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (toggle) cfg_start = 1'($urandom_range(0, 1));
    cfg_bit   = b;
    cfg_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if ((which ? cfg_ready1 : cfg_ready) === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL ready_timeout: got cfg_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input bit which, input logic [MS-1:0] w, input bit gaps,
                           input bit toggle, input bit bad_par);
    for (int k = 0; k < MS; k++) send_bit(which, w[k], gaps, toggle);
    if (PB != 0) send_bit(which, (^w) ^ bad_par, gaps, toggle);
  endtask

  task automatic run_frame(input bit gaps, input bit toggle, input logic [NB-1:0] bad_mask);
    q.delete();
    done_cnt  = 0;
    first_acc = -1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < NB; i++) send_word(1'b0, tbl[i].word, gaps, toggle, bad_mask[i]);
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    for (int t = 0; t < 20 && done_cnt == 0; t++) @(posedge clk);
    if (done_cnt == 0) begin
      n_chk++;
      $display("FAIL done_timeout: got done_cnt=0 expected 1");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input string tag, input logic [NB-1:0] skip_mask);
    int j = 0;
    chk({tag, "_commit_count"}, 32'(q.size()), 32'(NB - $countones(skip_mask)));
    for (int i = 0; i < NB; i++) begin
      if (skip_mask[i]) continue;
      if (j < q.size()) begin
        chk({tag, "_comb_set"}, 32'(q[j].set), 32'(tbl[i].exp_set));
        chk({tag, "_config_out"}, 32'(q[j].data), 32'(tbl[i].word));
      end
      j++;
    end
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      tbl[i].word    = 16'hA5F0 + 16'(i);
      tbl[i].exp_set = 8'(1 << i);
    end
    rst_n = 1'b0; cfg_start = 1'b0; cfg_start1 = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_config_out", 32'(config_out), 32'd0);
    chk("rst_comb_set", 32'(comb_set), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(cfg_ready), 32'd0);

    // Reset in the middle of word 2
    @(posedge clk); #1;
    q.delete();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    send_word(1'b0, tbl[0].word, 1'b0, 1'b0, 1'b0);
    send_word(1'b0, tbl[1].word, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'b0, tbl[2].word[k], 1'b0, 1'b0);
    cfg_valid = 1'b0;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    chk("midrst_config_out", 32'(config_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_commits", 32'(q.size()), 32'd2);
    if (q.size() >= 2) begin
      chk("midrst_set1", 32'(q[1].set), 32'(tbl[1].exp_set));
      chk("midrst_data1", 32'(q[1].data), 32'(tbl[1].word));
    end
    chk("midrst_idle_busy", 32'(busy), 32'd0);
    chk("midrst_idle_comb_set", 32'(comb_set), 32'd0);

    // Back-to-back frame
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, '0);
    compare_frame("b2b", '0);
    chk("b2b_frame_cycles", 32'(done_cyc - first_acc), 32'(NB * (WB + 1)));
    chk("b2b_config_out_hold", 32'(config_out), 32'(tbl[NB-1].word));
    chk("b2b_err", 32'(err), 32'd0);

    // Random valid gaps with cfg_start toggling mid-frame
    run_frame(1'b1, 1'b1, '0);
    compare_frame("gaps", '0);

    // Single-block instance: commit then done in the following cycle
    cfg_start1 = 1'b1;
    @(posedge clk); #1;
    cfg_start1 = 1'b0;
    send_word(1'b1, 16'h3C5A, 1'b0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("nb1_comb_set", 32'(comb_set1), 32'd1);
    chk("nb1_config_out", 32'(config_out1), 32'h3C5A);
    chk("nb1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    chk("nb1_done", 32'(done1), 32'd1);
    chk("nb1_comb_set_off", 32'(comb_set1), 32'd0);
    chk("nb1_busy_in_done", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("nb1_idle", 32'(busy1), 32'd0);
    chk("nb1_done_pulse", 32'(done1), 32'd0);

`ifdef CONFIG_PARITY_EN
    // Bad parity on word 1: no strobe, sticky err, later words still commit
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, 8'b0000_0010);
    compare_frame("par", 8'b0000_0010);
    chk("par_err_sticky", 32'(err), 32'd1);
    chk("par_err_cfg_out_held", 32'(err_rise_data), 32'(tbl[0].word));
    chk("par_err_no_strobe", 32'(err_rise_set), 32'd0);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("par_err_cleared", 32'(err), 32'd0);
    chk("par_restart_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
